// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SIGNED_MIN    = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with busy/done handshake.
// Multiply and divide share one double-width accumulator: for multiplies it
// holds {partial_high, multiplier}, for divides {remainder, quotient}.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [DW-1:0]    ALL_ONES = DW'(DIV_BY_ZERO_Q);
  localparam logic [DW-1:0]    MIN_NEG  = DW'(SIGNED_MIN);
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(DATA_WIDTH - 1);

  muldiv_state_e     state;
  muldiv_op_e        op_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*DW-1:0]   acc;
  logic [DW-1:0]     mag_b_q;
  logic              neg_q;

  // Start-time decode: signedness, magnitudes, result sign and fast path
  muldiv_op_e        op_in;
  logic              a_signed_c, b_signed_c, a_neg_c, b_neg_c, neg_in_c;
  logic [DW-1:0]     mag_a_c, mag_b_c;
  logic              fast_c;
  logic [DW-1:0]     fast_res_c;

  always_comb begin
    op_in      = muldiv_op_e'(funct3);
    a_signed_c = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed_c = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_neg_c    = a_signed_c & op_a[DW-1];
    b_neg_c    = b_signed_c & op_b[DW-1];
    mag_a_c    = a_neg_c ? DW'(-op_a) : op_a;
    mag_b_c    = b_neg_c ? DW'(-op_b) : op_b;
    // Remainder takes the dividend sign; everything else XORs both signs
    neg_in_c   = (op_in == OP_REM) ? a_neg_c : (a_neg_c ^ b_neg_c);
    fast_c     = 1'b0;
    fast_res_c = '0;
    if (funct3[2] && (op_b == '0)) begin
      fast_c     = 1'b1;
      fast_res_c = funct3[1] ? op_a : ALL_ONES;
    end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                 (op_a == MIN_NEG) && (op_b == ALL_ONES)) begin
      fast_c     = 1'b1;
      fast_res_c = funct3[1] ? '0 : MIN_NEG;
    end
  end

  // One radix-2 iteration plus the sign fixup / result select of the last one
  logic [DW:0]     mul_sum_c;
  logic [2*DW-1:0] mul_next_c;
  logic [DW:0]     rem_sh_c;
  logic [DW:0]     div_diff_c;
  logic [2*DW-1:0] div_next_c;
  logic [2*DW-1:0] acc_next_c;
  logic [2*DW-1:0] prod_c;
  logic [DW-1:0]   quo_c, rem_c;
  logic [DW-1:0]   final_c;

  always_comb begin
    mul_sum_c  = {1'b0, acc[2*DW-1:DW]} + {1'b0, (acc[0] ? mag_b_q : {DW{1'b0}})};
    mul_next_c = {mul_sum_c, acc[DW-1:1]};
    rem_sh_c   = acc[2*DW-1:DW-1];
    div_diff_c = rem_sh_c - {1'b0, mag_b_q};
    // Restoring step: keep the shifted remainder when the subtract borrows
    div_next_c = div_diff_c[DW] ? {rem_sh_c[DW-1:0], acc[DW-2:0], 1'b0}
                                : {div_diff_c[DW-1:0], acc[DW-2:0], 1'b1};
    acc_next_c = op_q[2] ? div_next_c : mul_next_c;
    prod_c     = neg_q ? (2*DW)'(-acc_next_c) : acc_next_c;
    quo_c      = neg_q ? DW'(-acc_next_c[DW-1:0]) : acc_next_c[DW-1:0];
    rem_c      = neg_q ? DW'(-acc_next_c[2*DW-1:DW]) : acc_next_c[2*DW-1:DW];
    final_c    = '0;
    case (op_q)
      OP_MUL:                        final_c = prod_c[DW-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_c = prod_c[2*DW-1:DW];
      OP_DIV, OP_DIVU:               final_c = quo_c;
      OP_REM, OP_REMU:               final_c = rem_c;
      default:                       final_c = '0;
    endcase
  end

  // Control FSM and datapath registers; flush overrides every transition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      op_q    <= OP_MUL;
      cnt     <= '0;
      acc     <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (fast_c) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= fast_res_c;
            end else begin
              state   <= CALC;
              op_q    <= op_in;
              cnt     <= '0;
              acc     <= {{DW{1'b0}}, mag_a_c};
              mag_b_q <= mag_b_c;
              neg_q   <= neg_in_c;
            end
          end
        end
        CALC: begin
          acc <= acc_next_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_IT) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= final_c;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: inputs driven and outputs sampled on the
// falling edge; cycle N is the Nth falling edge after the start edge.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_checks;
  int          n_fail;
  logic [31:0] last_exp;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one op and observe a fixed 39-cycle window (drives and records only)
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output int done_cnt,
                        output logic [31:0] res, output logic [39:0] btrace);
    done_cyc = -1;
    done_cnt = 0;
    res      = '0;
    btrace   = '0;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      start     = 1'b0;
      btrace[c] = busy;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          res      = result;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, result} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_hold: busy=%b done=%b result=%h, need 0/0/0", busy, done, result);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, result} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b done=%b result=%h, need 0/0/0", busy, done, result);
    end
  endtask

  task automatic test_multiply();
    string       nm [4] = '{"MUL", "MULH", "MULHU", "MULHSU"};
    logic [2:0]  fv [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] av [4] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bv [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [39:0] exp_busy = 40'h3_FFFF_FFFE;
    int dc, dn;
    logic [31:0] r;
    logic [39:0] bt;
    for (int i = 0; i < 4; i++) begin
      run_op(fv[i], av[i], bv[i], dc, dn, r, bt);
      n_checks += 3;
      if (dc != 33 || dn != 1) begin
        n_fail++;
        $display("FAIL %s_done: cycle=%0d pulses=%0d, need cycle 33 once", nm[i], dc, dn);
      end
      if (r !== ev[i]) begin
        n_fail++;
        $display("FAIL %s_result: got %h, need %h", nm[i], r, ev[i]);
      end
      if (bt !== exp_busy) begin
        n_fail++;
        $display("FAIL %s_busy: trace %h, need %h", nm[i], bt, exp_busy);
      end
    end
  endtask

  task automatic test_divide();
    string       nm [4] = '{"DIV", "REM", "DIVU", "REMU"};
    logic [2:0]  fv [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] av [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bv [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ev [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [39:0] exp_busy = 40'h3_FFFF_FFFE;
    int dc, dn;
    logic [31:0] r;
    logic [39:0] bt;
    for (int i = 0; i < 4; i++) begin
      run_op(fv[i], av[i], bv[i], dc, dn, r, bt);
      n_checks += 3;
      if (dc != 33 || dn != 1) begin
        n_fail++;
        $display("FAIL %s_done: cycle=%0d pulses=%0d, need cycle 33 once", nm[i], dc, dn);
      end
      if (r !== ev[i]) begin
        n_fail++;
        $display("FAIL %s_result: got %h, need %h", nm[i], r, ev[i]);
      end
      if (bt !== exp_busy) begin
        n_fail++;
        $display("FAIL %s_busy: trace %h, need %h", nm[i], bt, exp_busy);
      end
    end
  endtask

  task automatic test_fast_path();
    string       nm [5] = '{"DIVU_by0", "REM_by0", "DIV_ovf", "REM_ovf", "REMU_min_by_ones"};
    logic [2:0]  fv [5] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b111};
    logic [31:0] av [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'h8000_0000};
    int          lv [5] = '{1, 1, 1, 1, 33};
    logic [39:0] exp_busy;
    int dc, dn;
    logic [31:0] r;
    logic [39:0] bt;
    for (int i = 0; i < 5; i++) begin
      exp_busy = ((40'h1 << (lv[i] + 1)) - 40'h1) & ~40'h1;
      run_op(fv[i], av[i], bv[i], dc, dn, r, bt);
      n_checks += 3;
      if (dc != lv[i] || dn != 1) begin
        n_fail++;
        $display("FAIL %s_done: cycle=%0d pulses=%0d, need cycle %0d once", nm[i], dc, dn, lv[i]);
      end
      if (r !== ev[i]) begin
        n_fail++;
        $display("FAIL %s_result: got %h, need %h", nm[i], r, ev[i]);
      end
      if (bt !== exp_busy) begin
        n_fail++;
        $display("FAIL %s_busy: trace %h, need %h", nm[i], bt, exp_busy);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int dc = -1;
    int dn = 0;
    logic [31:0] r = '0;
    logic [39:0] bt = '0;
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD; start = 1'b1;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      bt[c] = busy;
      if (done === 1'b1) begin
        dn++;
        if (dc < 0) begin dc = c; r = result; end
      end
      // second request in cycle 10 must be dropped
      if (c == 10) begin
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    last_exp = 32'hFFFF_FFEB;
    n_checks += 3;
    if (dc != 33 || dn != 1) begin
      n_fail++;
      $display("FAIL busy_start_done: cycle=%0d pulses=%0d, need cycle 33 once", dc, dn);
    end
    if (r !== 32'hFFFF_FFEB) begin
      n_fail++;
      $display("FAIL busy_start_result: got %h, need ffffffeb", r);
    end
    if (bt !== 40'h3_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL busy_start_busy: trace %h, need 3fffffffe", bt);
    end
  endtask

  task automatic test_flush();
    int dn = 0;
    int dc;
    logic [31:0] r;
    logic [39:0] bt;
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 15) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: busy=%b done=%b, need 0/0", busy, done);
    end
    for (int c = 17; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    n_checks += 2;
    if (dn != 0) begin
      n_fail++;
      $display("FAIL flush_no_done: %0d pulses, need 0", dn);
    end
    if (result !== last_exp) begin
      n_fail++;
      $display("FAIL flush_result_hold: got %h, need %h", result, last_exp);
    end
    // flush beats a start presented in IDLE
    funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_over_start: busy=%b, need 0", busy);
    end
    run_op(3'b111, 32'd100, 32'd7, dc, dn, r, bt);
    n_checks += 2;
    if (dc != 33 || dn != 1) begin
      n_fail++;
      $display("FAIL post_flush_done: cycle=%0d pulses=%0d, need cycle 33 once", dc, dn);
    end
    if (r !== 32'd2) begin
      n_fail++;
      $display("FAIL post_flush_result: got %h, need 00000002", r);
    end
  endtask

  task automatic test_async_reset();
    int dc, dn;
    logic [31:0] r;
    logic [39:0] bt;
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_busy: busy=%b, need 1", busy);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, result} !== 34'h0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b result=%h, need 0/0/0", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(3'b000, 32'd3, 32'd4, dc, dn, r, bt);
    n_checks += 2;
    if (dc != 33 || dn != 1) begin
      n_fail++;
      $display("FAIL post_reset_done: cycle=%0d pulses=%0d, need cycle 33 once", dc, dn);
    end
    if (r !== 32'd12) begin
      n_fail++;
      $display("FAIL post_reset_result: got %h, need 0000000c", r);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_exp = '0;
    test_reset();
    test_multiply();
    test_divide();
    test_fast_path();
    test_start_while_busy();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
